// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch-stage widths, reset vector and the
// next-PC source select used by both control and the PC sequencer.
package mips_pkg;

   localparam int unsigned     PC_W         = 32;
   localparam int unsigned     INSN_BYTES   = 4;
   localparam logic [PC_W-1:0] RESET_VECTOR = '0;

   typedef enum logic [1:0] {
      PC_SEQ = 2'd0,
      PC_BR  = 2'd1,
      PC_J   = 2'd2,
      PC_JR  = 2'd3
   } pc_sel_e;

   // Fixed redirect priority: jr > jump > taken branch > sequential.
   function automatic pc_sel_e sel_pc(input logic jr, input logic jump, input logic br_taken);
      if (jr)
         return PC_JR;
      else if (jump)
         return PC_J;
      else if (br_taken)
         return PC_BR;
      else
         return PC_SEQ;
   endfunction

endpackage

// File: rtl/pc_step_adder.sv
// Sequential-address adder: pc + STEP, wrapping modulo 2^WIDTH.
// Shared by the PC sequencer and the link-address logic.
module pc_step_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 4
) (
   input  logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus
);

   always_comb begin
      pc_plus = pc + WIDTH'(STEP);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with next-PC selection (seq/branch/jump/jr)
// and a one-deep redirect buffer that holds a target raised while stalled.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter int unsigned      WIDTH    = PC_W,
   parameter int unsigned      STEP     = INSN_BYTES,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR),
   parameter int unsigned      IMM_W    = 16,
   parameter int unsigned      JTGT_W   = 26
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [IMM_W-1:0]  br_imm,
   input  logic              jump,
   input  logic [JTGT_W-1:0] jtgt,
   input  logic              jr,
   input  logic [WIDTH-1:0]  jr_addr,
   output logic [WIDTH-1:0]  pc,
   output logic [WIDTH-1:0]  pc_plus,
   output logic              redir_pend,
   output logic              misalign
);

   localparam int unsigned SH  = (STEP > 1) ? $clog2(STEP) : 0;
   localparam int unsigned JLO = (JTGT_W + SH < WIDTH) ? JTGT_W + SH : WIDTH;

   // Masks replace bit slicing so STEP=1 and narrow WIDTH need no special cases.
   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
   localparam logic [WIDTH-1:0] J_MASK   = (JLO >= WIDTH) ? '1 : ~({WIDTH{1'b1}} << JLO);

   logic signed [IMM_W-1:0] imm_s;
   logic [WIDTH-1:0]        br_off;
   logic [WIDTH-1:0]        br_tgt;
   logic [WIDTH-1:0]        j_tgt;
   logic [WIDTH-1:0]        jr_tgt;
   logic [WIDTH-1:0]        nxt_tgt;
   logic [WIDTH-1:0]        pend_tgt;
   logic                    redirect;
   logic                    jr_misalign;
   pc_sel_e                 sel;

   pc_step_adder #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .pc      (pc),
      .pc_plus (pc_plus)
   );

   always_comb begin
      imm_s       = br_imm;
      br_off      = WIDTH'(imm_s) << SH;
      br_tgt      = pc_plus + br_off;
      j_tgt       = (pc_plus & ~J_MASK) | ((WIDTH'(jtgt) << SH) & J_MASK);
      jr_tgt      = jr_addr & ~LOW_MASK;
      jr_misalign = jr && (|(jr_addr & LOW_MASK));
      sel         = sel_pc(jr, jump, br_taken);
      redirect    = (sel != PC_SEQ);
      nxt_tgt     = pc_plus;
      unique case (sel)
         PC_JR:   nxt_tgt = jr_tgt;
         PC_J:    nxt_tgt = j_tgt;
         PC_BR:   nxt_tgt = br_tgt;
         default: nxt_tgt = pc_plus;
      endcase
   end

   // While stalled pc is frozen, so a captured target cannot drift; the youngest redirect wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         pend_tgt   <= '0;
         redir_pend <= 1'b0;
         misalign   <= 1'b0;
      end else begin
         misalign <= jr_misalign;
         if (stall) begin
            if (redirect) begin
               pend_tgt   <= nxt_tgt;
               redir_pend <= 1'b1;
            end
         end else begin
            redir_pend <= 1'b0;
            if (redirect)
               pc <= nxt_tgt;
            else if (redir_pend)
               pc <= pend_tgt;
            else
               pc <= pc_plus;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: default 32-bit instance plus a
// WIDTH=16/STEP=2 instance, expected results queued and checked per edge.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        stall, br_taken, jump, jr;
   logic [15:0] br_imm;
   logic [25:0] jtgt;
   logic [31:0] jr_addr;
   logic [31:0] pc, pc_plus;
   logic        redir_pend, misalign;

   logic        stall16, br_taken16, jump16, jr16;
   logic [7:0]  br_imm16;
   logic [7:0]  jtgt16;
   logic [15:0] jr_addr16;
   logic [15:0] pc16, pc_plus16;
   logic        redir_pend16, misalign16;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   typedef struct {
      bit          w16;
      logic [31:0] pc;
      logic        pend;
      logic        mis;
      string       tag;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pc_sequencer u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_imm     (br_imm),
      .jump       (jump),
      .jtgt       (jtgt),
      .jr         (jr),
      .jr_addr    (jr_addr),
      .pc         (pc),
      .pc_plus    (pc_plus),
      .redir_pend (redir_pend),
      .misalign   (misalign)
   );

   pc_sequencer #(
      .WIDTH    (16),
      .STEP     (2),
      .RESET_PC (16'h0000),
      .IMM_W    (8),
      .JTGT_W   (8)
   ) u_dut16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall16),
      .br_taken   (br_taken16),
      .br_imm     (br_imm16),
      .jump       (jump16),
      .jtgt       (jtgt16),
      .jr         (jr16),
      .jr_addr    (jr_addr16),
      .pc         (pc16),
      .pc_plus    (pc_plus16),
      .redir_pend (redir_pend16),
      .misalign   (misalign16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Queue the expectation for the coming edge, then check it 1 time unit after that edge.
   task automatic step(input bit w16, input logic [31:0] epc, input logic epend,
                       input logic emis, input string tag);
      exp_t e;
      e.w16 = w16; e.pc = epc; e.pend = epend; e.mis = emis; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         if (e.w16) begin
            chk({e.tag, ".pc"},      {16'h0, pc16},         e.pc);
            chk({e.tag, ".pc_plus"}, {16'h0, pc_plus16},    (e.pc + 32'd2) & 32'h0000_FFFF);
            chk({e.tag, ".pend"},    {31'h0, redir_pend16}, {31'h0, e.pend});
            chk({e.tag, ".mis"},     {31'h0, misalign16},   {31'h0, e.mis});
         end else begin
            chk({e.tag, ".pc"},      pc,                  e.pc);
            chk({e.tag, ".pc_plus"}, pc_plus,             e.pc + 32'd4);
            chk({e.tag, ".pend"},    {31'h0, redir_pend}, {31'h0, e.pend});
            chk({e.tag, ".mis"},     {31'h0, misalign},   {31'h0, e.mis});
         end
      end
   endtask

   initial begin
      logic [31:0] mpc;
      rst_n = 1'b0;
      stall = 1'b0; br_taken = 1'b0; br_imm = '0; jump = 1'b0; jtgt = '0; jr = 1'b0; jr_addr = '0;
      stall16 = 1'b0; br_taken16 = 1'b0; br_imm16 = '0; jump16 = 1'b0; jtgt16 = '0;
      jr16 = 1'b0; jr_addr16 = '0;

      #3;
      chk("rst.pc",   pc,                  32'h0);
      chk("rst.pend", {31'h0, redir_pend}, 32'h0);
      chk("rst.mis",  {31'h0, misalign},   32'h0);
      chk("rst.pc16", {16'h0, pc16},       32'h0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 32'h4, 1'b0, 1'b0, "seq1");
      step(1'b0, 32'h8, 1'b0, 1'b0, "seq2");

      // asynchronous reset between edges
      #2; rst_n = 1'b0; #1;
      chk("arst.pc",   pc,                  32'h0);
      chk("arst.pend", {31'h0, redir_pend}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 32'h4, 1'b0, 1'b0, "arst.seq");

      // branch backwards
      jr = 1'b1; jr_addr = 32'h100;
      step(1'b0, 32'h100, 1'b0, 1'b0, "jr100");
      jr = 1'b0; br_taken = 1'b1; br_imm = 16'hFFFE;
      step(1'b0, 32'hFC, 1'b0, 1'b0, "br_neg");
      br_taken = 1'b0;

      // priority and misalign
      jr = 1'b1; jr_addr = 32'h40;
      step(1'b0, 32'h40, 1'b0, 1'b0, "jr40");
      jr_addr = 32'h2000; jump = 1'b1; jtgt = 26'h10; br_taken = 1'b1; br_imm = 16'h0004;
      step(1'b0, 32'h2000, 1'b0, 1'b0, "prio");
      jr_addr = 32'h2003;
      step(1'b0, 32'h2000, 1'b0, 1'b1, "prio.mis");
      jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
      step(1'b0, 32'h2004, 1'b0, 1'b0, "mis.pulse");

      // stall with captured jump
      jr = 1'b1; jr_addr = 32'h200;
      step(1'b0, 32'h200, 1'b0, 1'b0, "jr200");
      jr = 1'b0; stall = 1'b1; jump = 1'b1; jtgt = 26'h10;
      step(1'b0, 32'h200, 1'b1, 1'b0, "stall.cap");
      stall = 1'b0; jump = 1'b0;
      step(1'b0, 32'h40, 1'b0, 1'b0, "stall.rel");
      step(1'b0, 32'h44, 1'b0, 1'b0, "stall.seq");

      // youngest captured redirect wins; misaligned jr captured under stall
      stall = 1'b1; br_taken = 1'b1; br_imm = 16'h0004;
      step(1'b0, 32'h44, 1'b1, 1'b0, "ovr.br");
      br_taken = 1'b0; jr = 1'b1; jr_addr = 32'h802;
      step(1'b0, 32'h44, 1'b1, 1'b1, "ovr.jr");
      stall = 1'b0; jr = 1'b0;
      step(1'b0, 32'h800, 1'b0, 1'b0, "ovr.rel");

      // new redirect at release beats pending target
      stall = 1'b1; jump = 1'b1; jtgt = 26'h10;
      step(1'b0, 32'h800, 1'b1, 1'b0, "new.cap");
      stall = 1'b0; jump = 1'b0; jr = 1'b1; jr_addr = 32'h300;
      step(1'b0, 32'h300, 1'b0, 1'b0, "new.win");
      jr = 1'b0;

      // reset with redirect pending discards it
      stall = 1'b1; jump = 1'b1;
      step(1'b0, 32'h300, 1'b1, 1'b0, "rpend.cap");
      jump = 1'b0;
      #2; rst_n = 1'b0; #1;
      chk("rpend.pc",   pc,                  32'h0);
      chk("rpend.pend", {31'h0, redir_pend}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; stall = 1'b0;
      step(1'b0, 32'h4, 1'b0, 1'b0, "rpend.seq");

      // wrap
      jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
      step(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, "wrap.top");
      jr = 1'b0;
      step(1'b0, 32'h0, 1'b0, 1'b0, "wrap.seq");

      // random stall toggling over sequential fetch
      mpc = 32'h0;
      for (int i = 0; i < 20; i++) begin
         stall = 1'($urandom_range(0, 1));
         if (!stall) mpc = mpc + 32'd4;
         step(1'b0, mpc, 1'b0, 1'b0, "rnd");
      end
      stall = 1'b0;

      // WIDTH=16, STEP=2 instance
      jr16 = 1'b1; jr_addr16 = 16'hFFFE;
      step(1'b1, 32'hFFFE, 1'b0, 1'b0, "w16.top");
      jr16 = 1'b0;
      step(1'b1, 32'h0000, 1'b0, 1'b0, "w16.wrap");
      jr16 = 1'b1; jr_addr16 = 16'h0101;
      step(1'b1, 32'h0100, 1'b0, 1'b1, "w16.mis");
      jr16 = 1'b0; br_taken16 = 1'b1; br_imm16 = 8'hFF;
      step(1'b1, 32'h0100, 1'b0, 1'b0, "w16.br");
      br_taken16 = 1'b0;
      step(1'b1, 32'h0102, 1'b0, 1'b0, "w16.seq");
      jump16 = 1'b1; jtgt16 = 8'h05;
      step(1'b1, 32'h000A, 1'b0, 1'b0, "w16.j");
      jump16 = 1'b0;

      chk("sb.empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
